// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: shifts one row of pixels, blanks, latches, then holds the
// row on the panel for a brightness-weighted display window before the next row.
module hub75_scan_ctrl #(
   parameter int COLS      = 64,
   parameter int ROWS      = 16,
   parameter int DISP_UNIT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] brightness,
   output logic [6:0] col,
   output logic [3:0] shift_row,
   output logic [3:0] addr,
   output logic       sclk,
   output logic       lat,
   output logic       oe,
   output logic       busy,
   output logic       frame_done
);

   localparam int WIN = 16 * DISP_UNIT;
   localparam int CW  = $clog2(WIN + 1);

   typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

   state_t          state, state_n;
   logic            phase, phase_n;
   logic [6:0]      col_n;
   logic [3:0]      shift_row_n, addr_n;
   logic [3:0]      bright_q, bright_q_n, bright_eff;
   logic [CW-1:0]   disp_cnt, disp_cnt_n, thr;
   logic            sclk_n, lat_n, oe_n, busy_n, frame_done_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= 1'b0;
         col        <= '0;
         shift_row  <= '0;
         addr       <= '0;
         bright_q   <= '0;
         disp_cnt   <= '0;
         sclk       <= 1'b0;
         lat        <= 1'b0;
         oe         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         phase      <= phase_n;
         col        <= col_n;
         shift_row  <= shift_row_n;
         addr       <= addr_n;
         bright_q   <= bright_q_n;
         disp_cnt   <= disp_cnt_n;
         sclk       <= sclk_n;
         lat        <= lat_n;
         oe         <= oe_n;
         busy       <= busy_n;
         frame_done <= frame_done_n;
      end
   end

   // Outputs are derived from the next state so each register shows the value
   // belonging to the state it will be in during the coming cycle.
   always_comb begin
      state_n      = state;
      phase_n      = phase;
      col_n        = col;
      shift_row_n  = shift_row;
      addr_n       = addr;
      bright_q_n   = bright_q;
      bright_eff   = bright_q;
      disp_cnt_n   = disp_cnt;
      frame_done_n = 1'b0;

      case (state)
         IDLE: begin
            if (en) begin
               state_n = SHIFT;
               col_n   = '0;
               phase_n = 1'b0;
            end
         end
         SHIFT: begin
            if (!phase) begin
               phase_n = 1'b1;
            end else begin
               phase_n = 1'b0;
               if (col == 7'(COLS - 1)) begin
                  col_n   = '0;
                  state_n = BLANK;
               end else begin
                  col_n = col + 7'd1;
               end
            end
         end
         BLANK: state_n = LATCH;
         LATCH: begin
            bright_q_n = brightness;
            bright_eff = brightness;
            disp_cnt_n = CW'(WIN - 1);
            state_n    = DISPLAY;
         end
         DISPLAY: begin
            if (disp_cnt != '0) begin
               disp_cnt_n = disp_cnt - CW'(1);
            end else begin
               if (shift_row == 4'(ROWS - 1)) begin
                  shift_row_n  = '0;
                  frame_done_n = 1'b1;
               end else begin
                  shift_row_n = shift_row + 4'd1;
               end
               phase_n = 1'b0;
               col_n   = '0;
               state_n = en ? SHIFT : IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (state_n == LATCH)
         addr_n = shift_row;

      // The window stays lit while the down-counter is at or above this threshold.
      thr = CW'(WIN - int'(bright_eff) * DISP_UNIT);

      sclk_n = (state_n == SHIFT) && phase_n;
      lat_n  = (state_n == LATCH);
      busy_n = (state_n != IDLE);

      oe_n = oe;
      case (state_n)
         IDLE, BLANK, LATCH: oe_n = 1'b1;
         DISPLAY:            oe_n = (disp_cnt_n < thr);
         default:            oe_n = oe;
      endcase
   end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Randomized bench for hub75_scan_ctrl: a row-timeline reference model predicts
// every output each cycle, plus scenario checks on edge counts and timing.
module tb_hub75_scan_ctrl;

   localparam int C    = 64;
   localparam int R    = 16;
   localparam int DU   = 8;
   localparam int ROWP = 2*C + 2 + 16*DU;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] brightness;
   logic [6:0] col;
   logic [3:0] shift_row;
   logic [3:0] addr;
   logic       sclk, lat, oe, busy, frame_done;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   bit m_active = 1'b0;
   int m_t      = 0;
   int m_row    = 0;
   int m_addr   = 0;
   int m_b      = 0;
   bit m_fd     = 1'b0;

   always #5 clk = ~clk;

   hub75_scan_ctrl #(.COLS(C), .ROWS(R), .DISP_UNIT(DU)) dut (
      .clk(clk), .rst(rst), .en(en), .brightness(brightness),
      .col(col), .shift_row(shift_row), .addr(addr), .sclk(sclk),
      .lat(lat), .oe(oe), .busy(busy), .frame_done(frame_done)
   );

   wire [19:0] dut_vec = {col, shift_row, addr, sclk, lat, oe, busy, frame_done};
   localparam logic [19:0] RESET_VEC = {7'd0, 4'd0, 4'd0, 5'b00100};

   // Model: position m_t inside a 258-cycle row timeline, or idle.
   task automatic model_step();
      if (rst) begin
         m_active = 1'b0; m_t = 0; m_row = 0; m_addr = 0; m_fd = 1'b0;
         return;
      end
      m_fd = 1'b0;
      if (!m_active) begin
         if (en) begin m_active = 1'b1; m_t = 0; end
      end else if (m_t == ROWP - 1) begin
         m_row    = (m_row + 1) % R;
         m_fd     = (m_row == 0);
         m_active = en;
         m_t      = 0;
      end else begin
         if (m_t == 2*C + 1) m_b = int'(brightness);
         m_t++;
         if (m_t == 2*C + 1) m_addr = m_row;
      end
   endtask

   function automatic logic [19:0] exp_vec();
      logic [6:0] c;
      logic s, l, o;
      if (!m_active) return {7'd0, 4'(m_row), 4'(m_addr), 4'b0010, m_fd};
      c = (m_t < 2*C) ? 7'(m_t / 2) : 7'd0;
      s = (m_t < 2*C) && (m_t % 2 == 1);
      l = (m_t == 2*C + 1);
      o = !((m_t >= 2*C + 2) && (m_t - (2*C + 2) < m_b * DU));
      return {c, 4'(m_row), 4'(m_addr), s, l, o, 1'b1, m_fd};
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         if (lat === 1'b1 && oe === 1'b0) begin
            errors++;
            $display("[TB] FAIL lat_oe_overlap cyc=%0d lat=%b oe=%b required oe=1", cyc, lat, oe);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; brightness = 4'($urandom_range(0, 15));
      cycle(); cycle();
      checks++;
      if (dut_vec !== RESET_VEC) begin
         errors++;
         $display("[TB] FAIL reset_values got=%h expected=%h", dut_vec, RESET_VEC);
      end
      rst = 1'b0;
      repeat (20) begin
         brightness = 4'($urandom_range(0, 15));
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL idle_hold cyc=%0d got=%h expected=%h", cyc, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_first_row();
      int edges = 0, bad_col = 0, lat_at = -1, oe_bad = 0, low = 0;
      logic prev_sclk = 1'b0;
      logic [3:0] lat_addr = 4'hF;
      en = 1'b1; brightness = 4'd8;
      for (int i = 0; i < ROWP; i++) begin
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL first_row cyc=%0d got=%h expected=%h", cyc, dut_vec, exp_vec());
         end
         if (sclk && !prev_sclk) begin
            if (col !== 7'(edges)) bad_col++;
            edges++;
         end
         prev_sclk = sclk;
         if (lat) begin lat_at = i; lat_addr = addr; end
         if (!oe) low++;
         if (oe !== !(i >= 130 && i < 194)) oe_bad++;
      end
      checks++;
      if (edges != C || bad_col != 0) begin
         errors++;
         $display("[TB] FAIL sclk_edges got=%0d bad_col=%0d expected=%0d bad_col=0", edges, bad_col, C);
      end
      checks++;
      if (lat_at != 129 || lat_addr !== 4'd0) begin
         errors++;
         $display("[TB] FAIL latch_timing got cycle=%0d addr=%0d expected cycle=129 addr=0", lat_at, lat_addr);
      end
      checks++;
      if (oe_bad != 0 || low != 64) begin
         errors++;
         $display("[TB] FAIL oe_duty_8 got low=%0d misplaced=%0d expected low=64 misplaced=0", low, oe_bad);
      end
      cycle();
      checks++;
      if (shift_row !== 4'd1 || col !== 7'd0 || sclk !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL second_shift row=%0d col=%0d sclk=%b busy=%b expected 1 0 0 1", shift_row, col, sclk, busy);
      end
   endtask

   task automatic test_brightness();
      int targets[2] = '{0, 15};
      foreach (targets[k]) begin
         int low = 0, run = 0, maxrun = 0, n = 0;
         do begin
            brightness = (m_t <= 2*C + 1) ? 4'(targets[k]) : 4'($urandom_range(0, 15));
            cycle();
            checks++;
            if (dut_vec !== exp_vec()) begin
               errors++;
               $display("[TB] FAIL bright_row cyc=%0d got=%h expected=%h", cyc, dut_vec, exp_vec());
            end
            if (!oe) begin low++; run++; if (run > maxrun) maxrun = run; end
            else run = 0;
            n++;
         end while (m_t != 0 && n < 400);
         checks++;
         if (low != targets[k] * DU || maxrun != targets[k] * DU) begin
            errors++;
            $display("[TB] FAIL bright_%0d got low=%0d run=%0d expected %0d", targets[k], low, maxrun, targets[k] * DU);
         end
      end
   endtask

   task automatic test_frame();
      int n = 0, k = 0, addr_bad = 0;
      while (frame_done !== 1'b1 && n < 5000) begin
         brightness = 4'($urandom_range(0, 15));
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL frame_run cyc=%0d got=%h expected=%h", cyc, dut_vec, exp_vec());
         end
         n++;
      end
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL frame_done_timeout got=%b expected=1", frame_done);
      end
      n = 0;
      do begin
         brightness = 4'($urandom_range(0, 15));
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL frame_run cyc=%0d got=%h expected=%h", cyc, dut_vec, exp_vec());
         end
         if (lat) begin
            if (addr !== 4'(k % R)) addr_bad++;
            k++;
         end
         n++;
      end while (frame_done !== 1'b1 && n < 5000);
      checks++;
      if (n != R * ROWP) begin
         errors++;
         $display("[TB] FAIL frame_period got=%0d expected=%0d", n, R * ROWP);
      end
      checks++;
      if (k != R || addr_bad != 0) begin
         errors++;
         $display("[TB] FAIL addr_sequence got latches=%0d bad=%0d expected %0d bad=0", k, addr_bad, R);
      end
      n = 0;
      do begin
         cycle();
         n++;
      end while (lat !== 1'b1 && n < 400);
      checks++;
      if (lat !== 1'b1 || addr !== 4'd0) begin
         errors++;
         $display("[TB] FAIL addr_wrap got lat=%b addr=%0d expected lat=1 addr=0", lat, addr);
      end
   endtask

   task automatic test_en_drop();
      int n = 0;
      logic [3:0] seen_addr = 4'hF;
      en = 1'b1;
      while (!(m_active && m_row == 5 && m_t == 10) && n < 5000) begin
         brightness = 4'($urandom_range(0, 15));
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL to_row5 cyc=%0d got=%h expected=%h", cyc, dut_vec, exp_vec());
         end
         n++;
      end
      en = 1'b0;
      n = 0;
      do begin
         brightness = 4'($urandom_range(0, 15));
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL en_drop cyc=%0d got=%h expected=%h", cyc, dut_vec, exp_vec());
         end
         if (lat) seen_addr = addr;
         if (busy) n++;
      end while (busy === 1'b1 && n < 400);
      checks++;
      if (n != ROWP - 11 || seen_addr !== 4'd5) begin
         errors++;
         $display("[TB] FAIL row5_complete got busy=%0d addr=%0d expected busy=%0d addr=5", n, seen_addr, ROWP - 11);
      end
      repeat (5) cycle();
      checks++;
      if (busy !== 1'b0 || oe !== 1'b1 || shift_row !== 4'd6) begin
         errors++;
         $display("[TB] FAIL idle_after_drop busy=%b oe=%b row=%0d expected 0 1 6", busy, oe, shift_row);
      end
      en = 1'b1;
      cycle();
      checks++;
      if (busy !== 1'b1 || col !== 7'd0 || shift_row !== 4'd6 || sclk !== 1'b0) begin
         errors++;
         $display("[TB] FAIL resume busy=%b col=%0d row=%0d sclk=%b expected 1 0 6 0", busy, col, shift_row, sclk);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      brightness = 4'd15;
      while (oe !== 1'b0 && n < 600) begin
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL pre_reset cyc=%0d got=%h expected=%h", cyc, dut_vec, exp_vec());
         end
         n++;
      end
      checks++;
      if (oe !== 1'b0) begin
         errors++;
         $display("[TB] FAIL oe_low_timeout got oe=%b expected 0", oe);
      end
      rst = 1'b1;
      cycle();
      checks++;
      if (dut_vec !== RESET_VEC) begin
         errors++;
         $display("[TB] FAIL reset_mid got=%h expected=%h", dut_vec, RESET_VEC);
      end
      rst = 1'b0; en = 1'b0;
      repeat (5) begin
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL post_reset cyc=%0d got=%h expected=%h", cyc, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 63) == 0) en = ~en;
         brightness = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 1499) == 0);
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL random cyc=%0d got=%h expected=%h", cyc, dut_vec, exp_vec());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; brightness = 4'd0;
      @(negedge clk);
      test_reset();
      test_first_row();
      test_brightness();
      test_frame();
      test_en_drop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog cyc=%0d expected completion", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
